// File: rtl/cook_pkg.sv
// Shared constants for the microwave cook sequencer: state codes and BCD limits.
package cook_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned BCD_MAX         = 9;
    localparam int unsigned SEC_TENS_RELOAD = 5;

endpackage

// File: rtl/bcd_countdown.sv
// Combinational one-second decrement of a 4-digit MM:SS BCD value, with zero flags.
module bcd_countdown
    import cook_pkg::*;
#(
    parameter int unsigned DW = DIGIT_W
) (
    input  logic [4*DW-1:0] i_time,
    output logic [4*DW-1:0] o_time,
    output logic            o_in_zero,
    output logic            o_out_zero
);

    localparam logic [DW-1:0] L_MAX    = DW'(BCD_MAX);
    localparam logic [DW-1:0] L_RELOAD = DW'(SEC_TENS_RELOAD);
    localparam logic [DW-1:0] L_ONE    = DW'(1);

    logic [DW-1:0] w_m10;
    logic [DW-1:0] w_m1;
    logic [DW-1:0] w_s10;
    logic [DW-1:0] w_s1;

    assign {w_m10, w_m1, w_s10, w_s1} = i_time;

    // Seconds tens above 5 are legal entries and simply count down through them.
    always_comb begin
        o_time = i_time;
        if (w_s1 != '0) begin
            o_time = {w_m10, w_m1, w_s10, w_s1 - L_ONE};
        end else if (w_s10 != '0) begin
            o_time = {w_m10, w_m1, w_s10 - L_ONE, L_MAX};
        end else if (w_m1 != '0) begin
            o_time = {w_m10, w_m1 - L_ONE, L_RELOAD, L_MAX};
        end else if (w_m10 != '0) begin
            o_time = {w_m10 - L_ONE, L_MAX, L_RELOAD, L_MAX};
        end
    end

    assign o_in_zero  = (i_time == '0);
    assign o_out_zero = (o_time == '0);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook controller: keypad time entry, start/pause/clear sequencing,
// one-second countdown and magnetron/done outputs, all registered.
module cook_sequencer
    import cook_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DIGIT_W  = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 startn,
    input  logic                 stopn,
    input  logic                 clrn,
    input  logic                 door_closed,
    input  logic                 key_valid,
    input  logic [DIGIT_W-1:0]   key_digit,
    output logic [4*DIGIT_W-1:0] time_bcd,
    output logic                 magnetron_on,
    output logic                 timer_done,
    output logic                 done_led,
    output logic [1:0]           state
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] L_TERM = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] L_ONE  = PW'(1);

    logic [1:0]           r_state;
    logic [4*DIGIT_W-1:0] r_time;
    logic [PW-1:0]        r_presc;
    logic                 r_start_d;
    logic                 r_stop_d;
    logic                 r_clr_d;
    logic                 r_mag;
    logic                 r_done_p;
    logic                 r_led;

    logic                 w_start_p;
    logic                 w_stop_p;
    logic                 w_clr_p;
    logic                 w_tick;
    logic                 w_key_ok;
    logic [4*DIGIT_W-1:0] w_dec_time;
    logic                 w_time_zero;
    logic                 w_dec_zero;
    logic [1:0]           w_state_nx;
    logic [4*DIGIT_W-1:0] w_time_nx;
    logic [PW-1:0]        w_presc_nx;
    logic                 w_done_evt;

    bcd_countdown #(.DW(DIGIT_W)) u_countdown (
        .i_time    (r_time),
        .o_time    (w_dec_time),
        .o_in_zero (w_time_zero),
        .o_out_zero(w_dec_zero)
    );

    assign w_start_p = r_start_d & ~startn;
    assign w_stop_p  = r_stop_d  & ~stopn;
    assign w_clr_p   = r_clr_d   & ~clrn;
    assign w_tick    = (r_state == ST_COOK) && (r_presc == L_TERM);
    assign w_key_ok  = key_valid && (key_digit <= DIGIT_W'(BCD_MAX));

    // Strict priority: a higher-ranked press consumes the cycle even when it has no effect.
    always_comb begin
        w_state_nx = r_state;
        w_time_nx  = r_time;
        w_done_evt = 1'b0;
        if (w_clr_p) begin
            w_state_nx = ST_IDLE;
            w_time_nx  = '0;
        end else if ((r_state == ST_COOK) && !door_closed) begin
            w_state_nx = ST_PAUSE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_stop_p) begin
                        w_state_nx = ST_IDLE;
                    end else if (w_start_p) begin
                        if (door_closed && !w_time_zero) w_state_nx = ST_COOK;
                    end else if (w_key_ok) begin
                        w_time_nx = {r_time[3*DIGIT_W-1:0], key_digit};
                    end
                end
                ST_COOK: begin
                    if (w_stop_p) begin
                        w_state_nx = ST_PAUSE;
                    end else if (w_tick) begin
                        w_time_nx = w_dec_time;
                        if (w_dec_zero) begin
                            w_state_nx = ST_DONE;
                            w_done_evt = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_stop_p) begin
                        w_state_nx = ST_IDLE;
                        w_time_nx  = '0;
                    end else if (w_start_p && door_closed) begin
                        w_state_nx = ST_COOK;
                    end
                end
                default: begin
                    if (w_stop_p) begin
                        w_state_nx = ST_IDLE;
                        w_time_nx  = '0;
                    end else if (w_start_p) begin
                        w_state_nx = ST_DONE;
                    end else if (w_key_ok) begin
                        w_state_nx = ST_IDLE;
                        w_time_nx  = {{(3*DIGIT_W){1'b0}}, key_digit};
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_presc_nx = '0;
        if ((w_state_nx == ST_COOK) && (r_state == ST_COOK) && !w_tick) begin
            w_presc_nx = r_presc + L_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_time    <= '0;
            r_presc   <= '0;
            r_start_d <= 1'b1;
            r_stop_d  <= 1'b1;
            r_clr_d   <= 1'b1;
            r_mag     <= 1'b0;
            r_done_p  <= 1'b0;
            r_led     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_time    <= w_time_nx;
            r_presc   <= w_presc_nx;
            r_start_d <= startn;
            r_stop_d  <= stopn;
            r_clr_d   <= clrn;
            r_mag     <= (w_state_nx == ST_COOK);
            r_done_p  <= w_done_evt;
            r_led     <= (w_state_nx == ST_DONE);
        end
    end

    assign state        = r_state;
    assign time_bcd     = r_time;
    assign magnetron_on = r_mag;
    assign timer_done   = r_done_p;
    assign done_led     = r_led;

endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
Microwave cook controller sitting above the on/off logic. It owns the cook-time register (MM:SS BCD), accepts keypad digits, and sequences start/pause/resume/clear. It counts down once per second and drives the magnetron enable and done indications. Door-interlock and stop/clear priority are enforced here cycle-accurately.

Parameters:
TICK_DIV, 50000000, clocks per countdown second (benches override to 4)
DIGIT_W, 4, width of one BCD digit

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
startn  in  1  start button, active-low, already synchronized/debounced
stopn  in  1  stop/pause button, active-low, already synchronized/debounced
clrn  in  1  clear button, active-low, already synchronized/debounced
door_closed  in  1  1 = door closed (level)
key_valid  in  1  one-cycle strobe, key_digit valid
key_digit  in  4  keypad digit, BCD 0-9
time_bcd  out  16  {m10,m1,s10,s1} remaining/entered time
magnetron_on  out  1  heater enable, high only in COOK
timer_done  out  1  one-cycle pulse on entry to DONE
done_led  out  1  high while in DONE
state  out  2  IDLE=0, COOK=1, PAUSE=2, DONE=3

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE, time_bcd=0, magnetron_on=0, timer_done=0, done_led=0, prescaler=0, button history regs=1. Takes priority over everything.
- Buttons are edge-triggered: press = previous sample 1, current sample 0. One action per press; holding low does nothing further.
- All outputs are registered. An action takes effect on the clk edge that samples the press; outputs change one clock after the press is first sampled low.
- Per-cycle priority, highest first: clrn press > door open > stopn press > countdown expiry > startn press > key_valid.
- clrn press (any state): state=IDLE, time=0000, magnetron off, done_led=0.
- IDLE: key_valid with digit<=9 shifts left: {m10,m1,s10,s1} <= {m1,s10,s1,digit}. Digits >9 are ignored. Start with door_closed=1 and time!=0 -> COOK. Start with time=0 or door open is ignored.
- COOK: magnetron_on=1. Prescaler counts 0..TICK_DIV-1 and is cleared on every entry to COOK. On terminal count, time decrements by one second:
  - s1>0: s1-1.
  - s1=0, s10>0: s10-1, s1=9.
  - ss=00, mm>0: mm decrements as a 2-digit BCD value, ss=59.
  - Seconds tens up to 9 are legal; e.g. 01:90 counts through 01:00 -> 00:59.
- COOK, on the decrement that yields 0000: state=DONE, timer_done pulses 1 cycle, magnetron_on=0 on that same edge.
- COOK, door_closed=0 or stop press: state=PAUSE, time held, magnetron_on=0. A same-cycle terminal tick is discarded, with no decrement.
- COOK: keys and start are ignored.
- PAUSE: start with door closed -> COOK (prescaler restarts at 0). Stop press -> IDLE with time=0000. Keys are ignored.
- DONE: done_led=1. Start is ignored. Stop press -> IDLE, time stays 0000. A valid key -> IDLE with time={0,0,0,digit} (register cleared first).
- Door open in IDLE, PAUSE or DONE has no state effect, but blocks start.

Decomposition:
- Shared package cook_pkg:
  - state encodings IDLE/COOK/PAUSE/DONE
  - DIGIT_W
  - BCD_MAX=9, SEC_TENS_RELOAD=5
- One sub-module bcd_countdown: combinational 4-digit MM:SS decrement with a zero flag, instantiated once.
- Remaining logic in cook_sequencer: FSM, edge detectors, prescaler, key shifter.

Test Plan:
- TICK_DIV=4. Keys 0,0,0,3. Door closed, start. -> magnetron_on=1 next cycle. time 0003->0002->0001->0000 at 4-clock intervals. timer_done single pulse, state=DONE, done_led=1, magnetron_on=0 on the edge reaching 0000.
- Load 0100, start, run 1 tick. -> time=0059 (minute borrow). Load 0090 -> after 1 tick 0089, after 90 ticks DONE.
- Cooking at 0030, door_closed->0. -> PAUSE next cycle, time frozen at 0030, magnetron_on=0. Close door, start -> COOK, first decrement exactly 4 clocks later.
- Cooking, stopn press in the same cycle as a terminal tick -> PAUSE with no decrement. Second stopn press -> IDLE, time=0000.
- startn held low 20 cycles after DONE, and start with time=0000 -> no state change. Key 12 -> ignored.
- resetn=0 mid-COOK at time 0042 -> all outputs reset next edge. clrn press during COOK -> IDLE, 0000, magnetron off.
